// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Imported by the fetch interface, the next-PC selector and the fetch_ctrl top.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: redirect and stall controls, the instruction memory port and the decode slot.
// The master modport is the fetch controller; the slave modport is its environment.
interface fetch_ctrl_if #(
  parameter int N = 64
);

  logic                         PCSrc_F;
  logic [N-1:0]                 PCBranch_F;
  logic                         stall_D;
  logic                         imem_ready;
  logic [fetch_pkg::INSTR_W-1:0] imem_rdata;
  logic                         imem_req;
  logic [N-1:0]                 imem_addr_F;
  logic [fetch_pkg::INSTR_W-1:0] instr_F;
  logic [N-1:0]                 pc_F;
  logic                         instr_valid_F;

  modport master (
    input  PCSrc_F,
    input  PCBranch_F,
    input  stall_D,
    input  imem_ready,
    input  imem_rdata,
    output imem_req,
    output imem_addr_F,
    output instr_F,
    output pc_F,
    output instr_valid_F
  );

  modport slave (
    output PCSrc_F,
    output PCBranch_F,
    output stall_D,
    output imem_ready,
    output imem_rdata,
    input  imem_req,
    input  imem_addr_F,
    input  instr_F,
    input  pc_F,
    input  instr_valid_F
  );

endinterface

// File: rtl/fetch_ctrl_pc_next.sv
// Next-PC selection: redirect (word aligned) beats sequential advance, otherwise hold.
// The increment wraps modulo 2^N silently.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] pc,
  input  logic         redirect,
  input  logic [N-1:0] target,
  input  logic         advance,
  output logic [N-1:0] pc_next
);

  logic [N-1:0] pc_inc;
  logic [N-1:0] target_aligned;
  logic         unused_target_lsb;

  assign pc_inc            = pc + N'(PC_INC);
  assign target_aligned    = {target[N-1:2], 2'b00};
  // Low target bits are discarded by alignment.
  assign unused_target_lsb = ^target[1:0];

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = target_aligned;
    end else if (advance) begin
      pc_next = pc_inc;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/FETCH/HOLD FSM with a single registered decode slot.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] BOOT  = FS_BOOT;
  localparam logic [1:0] FETCH = FS_FETCH;
  localparam logic [1:0] HOLD  = FS_HOLD;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [N-1:0]       pc;
  logic [N-1:0]       pc_next;

  logic [INSTR_W-1:0] instr_p0;
  logic [N-1:0]       pc_p0;
  logic               vld_p0;

  logic in_fetch;
  logic slot_free;
  logic consume;
  logic redirect;
  logic accept;
  logic discard;

  assign in_fetch  = (state == FETCH);
  assign slot_free = !vld_p0 || !bus.stall_D;
  assign consume   = vld_p0 && !bus.stall_D;
  // Redirects arriving while still in BOOT are ignored.
  assign redirect  = bus.PCSrc_F && (state != BOOT);
  assign accept    = in_fetch && !redirect && bus.imem_ready && slot_free;
  assign discard   = in_fetch && !redirect && bus.imem_ready && !slot_free;

  fetch_pc_next #(
    .N(N)
  ) u_pc_next (
    .pc       (pc),
    .redirect (redirect),
    .target   (bus.PCBranch_F),
    .advance  (accept),
    .pc_next  (pc_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          state_nxt = FETCH;
        end else if (discard) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !bus.stall_D) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_next;
    end
  end

  // Stage p0: decode slot register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
      pc_p0    <= '0;
    end else if (redirect) begin
      vld_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0   <= 1'b1;
      instr_p0 <= bus.imem_rdata;
      pc_p0    <= pc;
    end else if (consume) begin
      vld_p0 <= 1'b0;
    end
  end

  assign bus.imem_req      = in_fetch;
  assign bus.imem_addr_F   = pc;
  assign bus.instr_F       = instr_p0;
  assign bus.pc_F          = pc_p0;
  assign bus.instr_valid_F = vld_p0;

`ifdef FETCH_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) begin
        perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      end
      if (vld_p0 && bus.stall_D) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, stall/HOLD, redirect, PC wrap, mid-request reset.
// Counter checks are included when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.N(N)) bus ();
  fetch_ctrl_if #(.N(N)) bus_w ();

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h1000_0013 ^ {a[15:0], a[31:16]};
  endfunction

  assign bus.imem_rdata   = instr_of(bus.imem_addr_F);
  assign bus_w.imem_rdata = instr_of(bus_w.imem_addr_F);

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pf, ps, pf_w, ps_w;
`endif

  fetch_ctrl #(.N(N), .RESET_PC(64'h0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(pf), .perf_stall_cnt(ps)
`endif
  );

  fetch_ctrl #(.N(N), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk),
    .reset(reset),
    .bus(bus_w)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(pf_w), .perf_stall_cnt(ps_w)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid_F); end
    checks++; if (bus.instr_F !== 32'h0) begin errs++; $display("FAIL rst_instr got=%h exp=0", bus.instr_F); end
    checks++; if (bus.pc_F !== 64'h0) begin errs++; $display("FAIL rst_pc got=%h exp=0", bus.pc_F); end
    checks++; if (bus.imem_addr_F !== 64'h0) begin errs++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr_F); end
    reset = 1'b0;
    // In BOOT: redirect and a memory response must both be ignored
    bus.PCSrc_F    = 1'b1;
    bus.PCBranch_F = 64'h500;
    bus.imem_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL boot_req got=%b exp=0", bus.imem_req); end
    tick();
    bus.PCSrc_F = 1'b0;
    checks++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL boot_exit_req got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr_F !== 64'h0) begin errs++; $display("FAIL boot_redir_ignored got=%h exp=0", bus.imem_addr_F); end
    checks++; if (bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL boot_ready_ignored got=%b exp=0", bus.instr_valid_F); end
  endtask

  task automatic test_sequential();
    bus.imem_ready = 1'b1;
    bus.stall_D    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (bus.instr_valid_F !== 1'b1) begin errs++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, bus.instr_valid_F); end
      checks++; if (bus.pc_F !== 64'(4 * k)) begin errs++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, bus.pc_F, 64'(4 * k)); end
      checks++; if (bus.instr_F !== instr_of(64'(4 * k))) begin errs++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, bus.instr_F, instr_of(64'(4 * k))); end
      checks++; if (bus.imem_addr_F !== 64'(4 * k + 4)) begin errs++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, bus.imem_addr_F, 64'(4 * k + 4)); end
    end
  endtask

  task automatic test_stall();
    bus.stall_D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL hold_req[%0d] got=%b exp=0", i, bus.imem_req); end
      checks++; if (bus.instr_valid_F !== 1'b1) begin errs++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.instr_valid_F); end
      checks++; if (bus.pc_F !== 64'd16) begin errs++; $display("FAIL hold_pc[%0d] got=%h exp=10", i, bus.pc_F); end
      checks++; if (bus.instr_F !== instr_of(64'd16)) begin errs++; $display("FAIL hold_instr[%0d] got=%h exp=%h", i, bus.instr_F, instr_of(64'd16)); end
      checks++; if (bus.imem_addr_F !== 64'd20) begin errs++; $display("FAIL hold_addr[%0d] got=%h exp=14", i, bus.imem_addr_F); end
    end
    bus.stall_D = 1'b0;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL unhold_valid got=%b exp=0", bus.instr_valid_F); end
    checks++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL unhold_req got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr_F !== 64'd20) begin errs++; $display("FAIL unhold_addr got=%h exp=14", bus.imem_addr_F); end
    tick();
    checks++; if (bus.pc_F !== 64'd20 || bus.instr_valid_F !== 1'b1) begin errs++; $display("FAIL resume_pc got=%h/%b exp=14/1", bus.pc_F, bus.instr_valid_F); end
    checks++; if (bus.instr_F !== instr_of(64'd20)) begin errs++; $display("FAIL resume_instr got=%h exp=%h", bus.instr_F, instr_of(64'd20)); end
    tick();
    checks++; if (bus.pc_F !== 64'd24) begin errs++; $display("FAIL resume_next got=%h exp=18", bus.pc_F); end
    checks++; if (bus.imem_addr_F !== 64'd28) begin errs++; $display("FAIL resume_addr got=%h exp=1c", bus.imem_addr_F); end
  endtask

  task automatic test_redirect();
    bus.PCSrc_F    = 1'b1;
    bus.PCBranch_F = 64'h1003;
    tick();
    bus.PCSrc_F = 1'b0;
    checks++; if (bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL redir_valid got=%b exp=0", bus.instr_valid_F); end
    checks++; if (bus.imem_addr_F !== 64'h1000) begin errs++; $display("FAIL redir_addr got=%h exp=1000", bus.imem_addr_F); end
    tick();
    checks++; if (bus.pc_F !== 64'h1000 || bus.instr_valid_F !== 1'b1) begin errs++; $display("FAIL redir_first got=%h/%b exp=1000/1", bus.pc_F, bus.instr_valid_F); end
    checks++; if (bus.instr_F !== instr_of(64'h1000)) begin errs++; $display("FAIL redir_instr got=%h exp=%h", bus.instr_F, instr_of(64'h1000)); end
    bus.stall_D = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL redir_hold_req got=%b exp=0", bus.imem_req); end
    // Redirect while held and stalled must still win
    bus.PCSrc_F    = 1'b1;
    bus.PCBranch_F = 64'h2002;
    tick();
    bus.PCSrc_F = 1'b0;
    bus.stall_D = 1'b0;
    checks++; if (bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL hold_redir_valid got=%b exp=0", bus.instr_valid_F); end
    checks++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL hold_redir_req got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr_F !== 64'h2000) begin errs++; $display("FAIL hold_redir_addr got=%h exp=2000", bus.imem_addr_F); end
  endtask

  task automatic test_no_ready();
    bus.imem_ready = 1'b0;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b0 || bus.imem_addr_F !== 64'h2000) begin errs++; $display("FAIL wait_state got=%b/%h exp=0/2000", bus.instr_valid_F, bus.imem_addr_F); end
    bus.imem_ready = 1'b1;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b1 || bus.pc_F !== 64'h2000) begin errs++; $display("FAIL wait_accept got=%b/%h exp=1/2000", bus.instr_valid_F, bus.pc_F); end
    bus.imem_ready = 1'b0;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b0 || bus.imem_addr_F !== 64'h2004) begin errs++; $display("FAIL drain_valid got=%b/%h exp=0/2004", bus.instr_valid_F, bus.imem_addr_F); end
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    bus.stall_D    = 1'b1;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b1 || bus.pc_F !== 64'h2004) begin errs++; $display("FAIL stall_noresp_hold got=%b/%h exp=1/2004", bus.instr_valid_F, bus.pc_F); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr_F !== 64'h2008) begin errs++; $display("FAIL stall_noresp_req got=%b/%h exp=1/2008", bus.imem_req, bus.imem_addr_F); end
    bus.stall_D    = 1'b0;
    bus.imem_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    tick();
    checks++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL mid_pre_req got=%b exp=1", bus.imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid_F !== 1'b0) begin errs++; $display("FAIL mid_rst_ctrl got=%b/%b exp=0/0", bus.imem_req, bus.instr_valid_F); end
    checks++; if (bus.instr_F !== 32'h0 || bus.pc_F !== 64'h0) begin errs++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", bus.instr_F, bus.pc_F); end
    checks++; if (bus.imem_addr_F !== 64'h0) begin errs++; $display("FAIL mid_rst_addr got=%h exp=0", bus.imem_addr_F); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.instr_valid_F !== 1'b0 || bus.imem_addr_F !== 64'h0) begin errs++; $display("FAIL mid_boot_ignore got=%b/%h exp=0/0", bus.instr_valid_F, bus.imem_addr_F); end
    tick();
    checks++; if (bus.instr_valid_F !== 1'b1 || bus.pc_F !== 64'h0) begin errs++; $display("FAIL mid_first got=%b/%h exp=1/0", bus.instr_valid_F, bus.pc_F); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus_w.imem_addr_F !== 64'hFFFF_FFFF_FFFF_FFFC) begin errs++; $display("FAIL wrap_boot_addr got=%h exp=fffffffffffffffc", bus_w.imem_addr_F); end
    tick();
    tick();
    checks++; if (bus_w.pc_F !== 64'hFFFF_FFFF_FFFF_FFFC || bus_w.instr_valid_F !== 1'b1) begin errs++; $display("FAIL wrap_first got=%h/%b exp=fffffffffffffffc/1", bus_w.pc_F, bus_w.instr_valid_F); end
    checks++; if (bus_w.imem_addr_F !== 64'h0) begin errs++; $display("FAIL wrap_addr got=%h exp=0", bus_w.imem_addr_F); end
    tick();
    checks++; if (bus_w.pc_F !== 64'h0 || bus_w.imem_addr_F !== 64'h4) begin errs++; $display("FAIL wrap_next got=%h/%h exp=0/4", bus_w.pc_F, bus_w.imem_addr_F); end
  endtask

`ifdef FETCH_CTRL_PERF_EN
  task automatic test_perf();
    reset = 1'b1;
    tick();
    checks++; if (pf !== 32'd0 || ps !== 32'd0) begin errs++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", pf, ps); end
    bus.imem_ready = 1'b1;
    bus.stall_D    = 1'b0;
    reset = 1'b0;
    tick();
    repeat (10) tick();
    bus.imem_ready = 1'b0;
    bus.stall_D    = 1'b1;
    repeat (4) tick();
    checks++; if (pf !== 32'd10) begin errs++; $display("FAIL perf_fetch got=%0d exp=10", pf); end
    checks++; if (ps !== 32'd4) begin errs++; $display("FAIL perf_stall got=%0d exp=4", ps); end
    bus.stall_D = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.PCSrc_F      = 1'b0;
    bus.PCBranch_F   = '0;
    bus.stall_D      = 1'b0;
    bus.imem_ready   = 1'b0;
    bus_w.PCSrc_F    = 1'b0;
    bus_w.PCBranch_F = '0;
    bus_w.stall_D    = 1'b0;
    bus_w.imem_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_no_ready();
    test_reset_mid();
    test_wrap();
`ifdef FETCH_CTRL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
